// File: rtl/mult_cell_arbiter_pkg.sv
// Shared constants and the in-flight tag type for the multiply-cell arbiter.
// The tag id is sized for the largest legal requester count.
package mult_arb_pkg;

  localparam int NUM_REQ_MAX  = 8;
  localparam int NUM_REQ_DEF  = 4;
  localparam int CELL_LAT_DEF = 1;
  localparam int ID_W         = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_cell_arbiter_if.sv
// Requester, response and multiply-cell signals of the arbiter as one bundle.
// The slave side is the arbiter; the master side is the requesters plus the cell.
interface mult_cell_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_src1;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_src2;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0]              cell_src1;
  logic [DATA_W-1:0]              cell_src2;
  logic [DATA_W-1:0]              cell_result;

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready, cell_result,
    output req_ready, rsp_valid, rsp_result, cell_src1, cell_src2
  );

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready, cell_result,
    input  req_ready, rsp_valid, rsp_result, cell_src1, cell_src2
  );

endinterface

// File: rtl/mult_cell_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its encoded id.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  int idx;

  // Walk offsets from farthest to nearest so the closest eligible id wins.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_cell_arbiter.sv
// Shares one pipelined low-word multiply cell among NUM_REQ requesters:
// round-robin issue, id-tagged in-flight tracking, one-entry response buffers.
module mult_cell_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = 32,
  parameter int CELL_LAT = CELL_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mult_cell_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("mult_cell_arbiter: NUM_REQ out of range");
  end

  logic [ID_W-1:0]                ptr;
  logic [NUM_REQ-1:0]             busy;
  logic [NUM_REQ-1:0]             eligible;
  logic [NUM_REQ-1:0]             grant;
  logic [ID_W-1:0]                gnt_id;
  logic                           gnt_any;
  tag_t [CELL_LAT:0]              tag_pipe;
  logic [DATA_W-1:0]              src1_q, src2_q;
  logic [DATA_W-1:0]              src1_sel, src2_sel;
  logic [NUM_REQ-1:0]             land;
  logic [NUM_REQ-1:0]             rsp_valid_q;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_result_q;

  // A requester is busy while it has a product in flight or an unconsumed
  // result; this is what keeps each response buffer down to one entry.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      busy[i] = rsp_valid_q[i] & ~bus.rsp_ready[i];
      for (int s = 0; s <= CELL_LAT; s++) begin
        if (tag_pipe[s].valid && tag_pipe[s].id == ID_W'(i)) busy[i] = 1'b1;
      end
    end
  end

  assign eligible = bus.req_valid & ~busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .gnt_id   (gnt_id),
    .gnt_any  (gnt_any)
  );

  assign bus.req_ready = reset ? '0 : grant;

  always_comb begin
    src1_sel = '0;
    src2_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        src1_sel = bus.req_src1[i];
        src2_sel = bus.req_src2[i];
      end
    end
  end

  // Issue side: operand registers, tag shift register and rotation pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{valid: gnt_any, id: gnt_id};
      for (int s = 1; s <= CELL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (gnt_any) begin
        src1_q <= src1_sel;
        src2_q <= src2_sel;
        ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

  assign bus.cell_src1 = src1_q;
  assign bus.cell_src2 = src2_q;

  // The tag leaving the last stage lines up with the cell's product.
  always_comb begin
    land = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      land[i] = tag_pipe[CELL_LAT].valid && tag_pipe[CELL_LAT].id == ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (land[i]) begin
          rsp_valid_q[i]  <= 1'b1;
          rsp_result_q[i] <= bus.cell_result;
        end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
          rsp_valid_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;

  // Busy gating must make it impossible for a result to land on a full buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(|(land & rsp_valid_q)))
        else $error("mult_cell_arbiter: result landed on an occupied response buffer");
    end
  end

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Directed bench for mult_cell_arbiter: a cycle table for round-robin and
// backpressure, plus hand sequences for latency, wrap, reset and reissue.
module tb_mult_cell_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mult_cell_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  mult_cell_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CELL_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One-cycle multiply cell.
  always_ff @(posedge clk) bus.cell_result <= bus.cell_src1 * bus.cell_src2;

  typedef struct {
    logic [3:0] req_valid;
    logic [3:0] rsp_ready;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rv;
  } vec_t;

  vec_t        tbl [23];
  logic [31:0] exp_prod [4];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single issue on an idle arbiter: grant now, result exactly 3 cycles later.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    logic [3:0] oh;
    oh = 4'(1 << id);
    bus.req_valid    = oh;
    bus.req_src1[id] = a;
    bus.req_src2[id] = b;
    #1;
    chk({nm, " grant"}, 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = '0;
    #1;
    chk({nm, " early+1"}, 32'(bus.rsp_valid[id]), 32'd0);
    tick();
    #1;
    chk({nm, " early+2"}, 32'(bus.rsp_valid[id]), 32'd0);
    tick();
    #1;
    chk({nm, " valid+3"}, 32'(bus.rsp_valid), 32'(oh));
    chk({nm, " result"}, bus.rsp_result[id], exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.req_src1  = '0;
    bus.req_src2  = '0;

    // Reset state, with requests pending to show req_ready is gated.
    reset = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_result0", bus.rsp_result[0], 32'd0);
    chk("rst rsp_result3", bus.rsp_result[3], 32'd0);
    chk("rst cell_src1", bus.cell_src1, 32'd0);
    chk("rst cell_src2", bus.cell_src2, 32'd0);
    do_reset();

    // Basic latency: 3 x 5 on requester 0.
    bus.req_valid   = 4'b0001;
    bus.req_src1[0] = 32'd3;
    bus.req_src2[0] = 32'd5;
    #1;
    chk("s1 grant", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    #1;
    chk("s1 cell_src1", bus.cell_src1, 32'd3);
    chk("s1 cell_src2", bus.cell_src2, 32'd5);
    chk("s1 rv+1", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    chk("s1 hold cell_src1", bus.cell_src1, 32'd3);
    chk("s1 rv+2", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    chk("s1 rv+3", 32'(bus.rsp_valid), 32'b0001);
    chk("s1 result", bus.rsp_result[0], 32'd15);
    tick();
    #1;
    chk("s1 consumed", 32'(bus.rsp_valid), 32'd0);

    // Wrap-around products on requester 1.
    issue(1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "s2 wrap");
    issue(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "s2 zero");

    // Table: all four requesting, then requester 2 backpressured for 10 cycles.
    bus.req_src1[0] = 32'd3;          bus.req_src2[0] = 32'd5;
    bus.req_src1[1] = 32'hFFFF_FFFF;  bus.req_src2[1] = 32'd2;
    bus.req_src1[2] = 32'h0001_0003;  bus.req_src2[2] = 32'h0001_0000;
    bus.req_src1[3] = 32'd7;          bus.req_src2[3] = 32'd6;
    exp_prod[0] = 32'd15;
    exp_prod[1] = 32'hFFFF_FFFE;
    exp_prod[2] = 32'h0003_0000;
    exp_prod[3] = 32'd42;

    tbl[0]  = '{4'hF, 4'hF, 4'b0001, 4'b0000};
    tbl[1]  = '{4'hF, 4'hF, 4'b0010, 4'b0000};
    tbl[2]  = '{4'hF, 4'hF, 4'b0100, 4'b0000};
    tbl[3]  = '{4'hF, 4'hF, 4'b1000, 4'b0001};
    tbl[4]  = '{4'hF, 4'hF, 4'b0001, 4'b0010};
    tbl[5]  = '{4'hF, 4'hF, 4'b0010, 4'b0100};
    tbl[6]  = '{4'hF, 4'hF, 4'b0100, 4'b1000};
    tbl[7]  = '{4'hF, 4'hF, 4'b1000, 4'b0001};
    tbl[8]  = '{4'hF, 4'hF, 4'b0001, 4'b0010};
    tbl[9]  = '{4'hF, 4'hB, 4'b0010, 4'b0100};
    tbl[10] = '{4'hF, 4'hB, 4'b1000, 4'b1100};
    tbl[11] = '{4'hF, 4'hB, 4'b0001, 4'b0101};
    tbl[12] = '{4'hF, 4'hB, 4'b0010, 4'b0110};
    tbl[13] = '{4'hF, 4'hB, 4'b1000, 4'b1100};
    tbl[14] = '{4'hF, 4'hB, 4'b0001, 4'b0101};
    tbl[15] = '{4'hF, 4'hB, 4'b0010, 4'b0110};
    tbl[16] = '{4'hF, 4'hB, 4'b1000, 4'b1100};
    tbl[17] = '{4'hF, 4'hB, 4'b0001, 4'b0101};
    tbl[18] = '{4'hF, 4'hB, 4'b0010, 4'b0110};
    tbl[19] = '{4'hF, 4'hF, 4'b0100, 4'b1100};
    tbl[20] = '{4'hF, 4'hF, 4'b1000, 4'b0001};
    tbl[21] = '{4'hF, 4'hF, 4'b0001, 4'b0010};
    tbl[22] = '{4'hF, 4'hF, 4'b0010, 4'b0100};

    do_reset();
    for (int c = 0; c < 23; c++) begin
      bus.req_valid = tbl[c].req_valid;
      bus.rsp_ready = tbl[c].rsp_ready;
      #1;
      chk($sformatf("v%0d req_ready", c), 32'(bus.req_ready), 32'(tbl[c].exp_rdy));
      chk($sformatf("v%0d rsp_valid", c), 32'(bus.rsp_valid), 32'(tbl[c].exp_rv));
      for (int i = 0; i < NR; i++) begin
        if (tbl[c].exp_rv[i])
          chk($sformatf("v%0d rsp_result%0d", c, i), bus.rsp_result[i], exp_prod[i]);
      end
      tick();
    end

    // Reset one cycle after grants to 0 and 1: nothing may emerge afterwards.
    do_reset();
    bus.req_valid = 4'b0011;
    #1;
    chk("s3 grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    #1;
    chk("s3 grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    reset         = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("s3 in-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("s3 post-reset rv%0d", k), 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.req_src1[1] = 32'd6;
    bus.req_src2[1] = 32'd7;
    bus.req_valid   = 4'b1010;
    #1;
    chk("s3 ptr zero grant", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    chk("s3 post-reset rv", 32'(bus.rsp_valid), 32'b0010);
    chk("s3 post-reset result", bus.rsp_result[1], 32'd42);
    tick();

    // Reissue in the very cycle the held result is consumed.
    do_reset();
    bus.rsp_ready   = 4'b0111;
    bus.req_valid   = 4'b1000;
    bus.req_src1[3] = 32'd100;
    bus.req_src2[3] = 32'd3;
    #1;
    chk("s4 grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    chk("s4 rv", 32'(bus.rsp_valid), 32'b1000);
    chk("s4 result", bus.rsp_result[3], 32'd300);
    tick();
    bus.req_valid   = 4'b1000;
    bus.req_src1[3] = 32'h0000_1234;
    bus.req_src2[3] = 32'h0000_0010;
    #1;
    chk("s4 blocked while held", 32'(bus.req_ready), 32'd0);
    chk("s4 held rv", 32'(bus.rsp_valid), 32'b1000);
    tick();
    bus.rsp_ready = 4'hF;
    #1;
    chk("s4 same-cycle grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    #1;
    chk("s4 rv cleared", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    chk("s4 rv still clear", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    chk("s4 second rv", 32'(bus.rsp_valid), 32'b1000);
    chk("s4 second result", bus.rsp_result[3], 32'h0001_2340);
    tick();
    #1;
    chk("s4 no duplicate", 32'(bus.rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
